// File: rtl/note_event_sequencer.sv
// note_event_sequencer
// ---------------------------------------------------------------------------
// Host-loaded note event player. The host writes events (track, note,
// duration, velocity, gap) into an internal FIFO; on start the player pops
// them one by one, emits a one-cycle per-track command pulse on track_valid,
// updates that track's note/duration/velocity fields, then waits gap
// milliseconds (measured with a CLOCK_FREQ/1000 prescaler) before fetching
// the next event. Fields of a track hold until that track receives another
// event.
//
// Optional feature macro: SEQ_LOOP_EN
//   When defined, an extra input 'loop' is present. In FETCH with loop=1 the
//   popped event is written back at the FIFO tail in the same cycle, so the
//   queued sequence repeats until stop.
//
// Handshake: an event is written when ev_valid && ev_ready are both high at
// a rising clk edge. ev_ready does not depend on ev_valid. ev_valid may be
// held high; each accepting edge stores one event.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   ev_valid/ev_ready  event write handshake
//   ev_track..ev_gap_ms event fields (gap in ms, applied after issuing)
//   start, stop        playback control (start honoured in IDLE only)
//   loop               (SEQ_LOOP_EN only) repeat the queued sequence
//   busy               player not idle
//   done               one-cycle pulse when playback ran out of events
//   fifo_count         occupied FIFO entries
//   track_valid        one-hot command pulse, one bit per track
//   note_code, duration_ms, velocity  per-track packed fields
//   state_dbg          current FSM state (IDLE=0, FETCH=1, ISSUE=2, WAIT=3)
// ---------------------------------------------------------------------------
module note_event_sequencer #(
  parameter int CLOCK_FREQ = 44100000,
  parameter int NUM_TRACKS = 4,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic [$clog2(NUM_TRACKS)-1:0] ev_track,
  input  logic [11:0]                   ev_note,
  input  logic [15:0]                   ev_duration,
  input  logic [7:0]                    ev_velocity,
  input  logic [15:0]                   ev_gap_ms,
  input  logic                          start,
  input  logic                          stop,
`ifdef SEQ_LOOP_EN
  input  logic                          loop,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [NUM_TRACKS-1:0]         track_valid,
  output logic [NUM_TRACKS*12-1:0]      note_code,
  output logic [NUM_TRACKS*16-1:0]      duration_ms,
  output logic [NUM_TRACKS*8-1:0]       velocity,
  output logic [1:0]                    state_dbg
);

  localparam int TICK_DIV = CLOCK_FREQ / 1000;
  localparam int TW       = $clog2(NUM_TRACKS);
  localparam int AW       = $clog2(DEPTH);
  localparam int EW       = TW + 12 + 16 + 8 + 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and pointers
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full;
  logic          push, pop, host_push, loop_push, loop_en;
  logic [EW-1:0] push_data, head;

  // Head-of-FIFO fields
  logic [TW-1:0] h_trk;
  logic [11:0]   h_note;
  logic [15:0]   h_dur;
  logic [7:0]    h_vel;
  logic [15:0]   h_gap;
  logic [31:0]   h_trk_ext;

  // Event being issued / waited on
  logic [TW-1:0] trk_q;
  logic [15:0]   gap_q;
  logic [31:0]   trk_ext;

  // Millisecond timing
  logic [31:0] presc_q;
  logic [15:0] gap_cnt_q;
  logic        tick;

`ifdef SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (AW+1)'(DEPTH));
  assign head       = mem[rd_ptr_q];
  assign {h_trk, h_note, h_dur, h_vel, h_gap} = head;
  assign h_trk_ext  = 32'(h_trk);
  assign trk_ext    = 32'(trk_q);

  // The write port is borrowed by the loop re-push, so the host is held off
  // for that one FETCH cycle.
  assign ev_ready   = !fifo_full && !loop_push;
  assign host_push  = ev_valid && ev_ready;
  assign push       = host_push || loop_push;
  assign push_data  = loop_push ? head
                                : {ev_track, ev_note, ev_duration, ev_velocity, ev_gap_ms};

  assign tick       = (presc_q == 32'(TICK_DIV - 1));
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

  // Next-state logic. A stop in FETCH suppresses the pop so the head event
  // stays queued for a later resume.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    loop_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (stop || fifo_empty) begin
          state_d = S_IDLE;
        end else begin
          pop       = 1'b1;
          loop_push = loop_en;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stop)               state_d = S_IDLE;
        else if (gap_q == 16'd0) state_d = S_FETCH;
        else                    state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop)                             state_d = S_IDLE;
        else if (tick && gap_cnt_q == 16'd1)  state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command pulse: only in ISSUE, on the event's own track.
  always_comb begin
    track_valid = '0;
    if (state_q == S_ISSUE) begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        track_valid[i] = (trk_ext == 32'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FIFO storage is not reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // The popped event is written straight into its track's fields so they
  // are already valid during the ISSUE pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trk_q       <= '0;
      gap_q       <= '0;
      note_code   <= '0;
      duration_ms <= '0;
      velocity    <= '0;
    end else if (pop) begin
      trk_q <= h_trk;
      gap_q <= h_gap;
      for (int i = 0; i < NUM_TRACKS; i++) begin
        if (h_trk_ext == 32'(i)) begin
          note_code[12*i +: 12]   <= h_note;
          duration_ms[16*i +: 16] <= h_dur;
          velocity[8*i +: 8]      <= h_vel;
        end
      end
    end
  end

  // Gap timer: loaded in ISSUE, counts ms ticks in WAIT so that WAIT lasts
  // exactly gap*TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      gap_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      presc_q   <= '0;
      gap_cnt_q <= gap_q;
    end else if (state_q == S_WAIT) begin
      if (tick) begin
        presc_q   <= '0;
        gap_cnt_q <= gap_cnt_q - 16'd1;
      end else begin
        presc_q <= presc_q + 32'd1;
      end
    end else begin
      presc_q   <= '0;
      gap_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state_q == S_FETCH) && !stop && fifo_empty;
  end

endmodule

// File: tb/tb_note_event_sequencer.sv
// Testbench for note_event_sequencer. A queue-based reference model predicts,
// for each playback run, the cycle of every command pulse (first at start+2,
// then previous + gap*TICK + 2), the done cycle, busy span, fifo occupancy
// and the per-track field contents; the DUT is compared every cycle.
module tb_note_event_sequencer;

  localparam int CLOCK_FREQ = 4000;
  localparam int NUM_TRACKS = 4;
  localparam int DEPTH      = 16;
  localparam int TICK       = CLOCK_FREQ / 1000;

  typedef struct {
    logic [1:0]  trk;
    logic [11:0] note;
    logic [15:0] dur;
    logic [7:0]  vel;
    logic [15:0] gap;
  } ev_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [1:0]  ev_track = '0;
  logic [11:0] ev_note = '0;
  logic [15:0] ev_duration = '0;
  logic [7:0]  ev_velocity = '0;
  logic [15:0] ev_gap_ms = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
`ifdef SEQ_LOOP_EN
  logic        loop = 1'b0;
`endif
  logic        busy, done;
  logic [4:0]  fifo_count;
  logic [3:0]  track_valid;
  logic [47:0] note_code;
  logic [63:0] duration_ms;
  logic [31:0] velocity;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  note_event_sequencer #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .NUM_TRACKS(NUM_TRACKS),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_track(ev_track),
    .ev_note(ev_note),
    .ev_duration(ev_duration),
    .ev_velocity(ev_velocity),
    .ev_gap_ms(ev_gap_ms),
    .start(start),
    .stop(stop),
`ifdef SEQ_LOOP_EN
    .loop(loop),
`endif
    .busy(busy),
    .done(done),
    .fifo_count(fifo_count),
    .track_valid(track_valid),
    .note_code(note_code),
    .duration_ms(duration_ms),
    .velocity(velocity),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  ev_t mq[$];                 // model of FIFO contents
  logic [47:0] m_note = '0;   // model of per-track fields
  logic [63:0] m_dur = '0;
  logic [31:0] m_vel = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    mq.delete();
    m_note = '0; m_dur = '0; m_vel = '0;
    check_eq("rst_track_valid", track_valid, 0);
    check_eq("rst_note_code", note_code, 0);
    check_eq("rst_duration", duration_ms, 0);
    check_eq("rst_velocity", velocity, 0);
    check_eq("rst_ev_ready", ev_ready, 1);
    check_eq("rst_fifo_count", fifo_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_ev(input logic [1:0] trk, input logic [11:0] note,
                         input logic [15:0] dur, input logic [7:0] vel,
                         input logic [15:0] gap);
    ev_t e;
    bit acc;
    acc = (mq.size() < DEPTH);
    check_eq("push_ev_ready", ev_ready, acc);
    ev_valid = 1'b1; ev_track = trk; ev_note = note;
    ev_duration = dur; ev_velocity = vel; ev_gap_ms = gap;
    @(negedge clk);
    ev_valid = 1'b0;
    if (acc) begin
      e.trk = trk; e.note = note; e.dur = dur; e.vel = vel; e.gap = gap;
      mq.push_back(e);
    end
    check_eq("push_fifo_count", fifo_count, mq.size());
  endtask

  // Pulse start (with stop at relative cycle stop_rel, or never if < 0) and
  // compare every cycle against the model's predicted schedule.
  task automatic play(input int stop_rel, input bit loop_mode);
    ev_t q2[$];
    ev_t se[$];
    int  st[$];
    ev_t e;
    int  nxt, done_t, busy_last, n0, pops, exp_cnt;
    logic [3:0] exp_tv;
    bit  exp_rdy;
    q2 = mq; n0 = mq.size(); nxt = 2; done_t = -1;
    while (1) begin
      if (stop_rel >= 0 && nxt > stop_rel) break;
      if (q2.size() == 0) begin done_t = nxt; break; end
      e = q2.pop_front();
      st.push_back(nxt);
      se.push_back(e);
      if (loop_mode) q2.push_back(e);
      nxt = nxt + int'(e.gap) * TICK + 2;
    end
    busy_last = (done_t >= 0) ? done_t - 1 : stop_rel;

    start = 1'b1;
    stop  = (stop_rel == 0);
`ifdef SEQ_LOOP_EN
    loop  = loop_mode;
`endif
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int rel = 1; rel <= busy_last + 3; rel++) begin
      exp_tv = '0; pops = 0; exp_rdy = 1'b1;
      for (int j = 0; j < st.size(); j++) begin
        if (st[j] <= rel) pops++;
        if (st[j] == rel) begin
          exp_tv = 4'b0001 << se[j].trk;
          m_note[12*se[j].trk +: 12] = se[j].note;
          m_dur[16*se[j].trk +: 16]  = se[j].dur;
          m_vel[8*se[j].trk +: 8]    = se[j].vel;
        end
        if (loop_mode && st[j] == rel + 1) exp_rdy = 1'b0;
      end
      exp_cnt = loop_mode ? n0 : n0 - pops;
      if (exp_cnt >= DEPTH) exp_rdy = 1'b0;
      check_eq($sformatf("track_valid@%0d", rel), track_valid, exp_tv);
      check_eq($sformatf("note_code@%0d", rel), note_code, m_note);
      check_eq($sformatf("duration_ms@%0d", rel), duration_ms, m_dur);
      check_eq($sformatf("velocity@%0d", rel), velocity, m_vel);
      check_eq($sformatf("busy@%0d", rel), busy, rel <= busy_last);
      check_eq($sformatf("done@%0d", rel), done, rel == done_t);
      check_eq($sformatf("fifo_count@%0d", rel), fifo_count, exp_cnt);
      check_eq($sformatf("ev_ready@%0d", rel), ev_ready, exp_rdy);
      stop = (rel == stop_rel);
      @(negedge clk);
    end
    stop = 1'b0;
`ifdef SEQ_LOOP_EN
    loop = 1'b0;
`endif
    mq = q2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] scale [5];
    int n, sr;
    scale[0] = 12'd48; scale[1] = 12'd50; scale[2] = 12'd52;
    scale[3] = 12'd53; scale[4] = 12'd55;

    @(negedge clk);
    do_reset();

    // Scale on track 0, 2 ms gaps
    for (int i = 0; i < 5; i++) push_ev(2'd0, scale[i], 16'd500, 8'd127, 16'd2);
    play(-1, 1'b0);

    // Fill FIFO, 17th write refused, then drain back-to-back
    for (int i = 0; i < 17; i++)
      push_ev(2'(i % 4), 12'(60 + i), 16'(100 + i), 8'(i), 16'd0);
    play(-1, 1'b0);

    // Field retention across tracks
    push_ev(2'd2, 12'd60, 16'd250, 8'd90, 16'd0);
    push_ev(2'd1, 12'd64, 16'd300, 8'd80, 16'd0);
    play(-1, 1'b0);

    // start together with stop is ignored; a later start plays the event
    push_ev(2'd3, 12'd70, 16'd10, 8'd5, 16'd1);
    play(0, 1'b0);
    play(-1, 1'b0);

    // stop three cycles into the first WAIT, then resume
    for (int i = 0; i < 3; i++) push_ev(2'd1, 12'(72 + i), 16'd40, 8'd33, 16'd5);
    play(5, 1'b0);
    play(-1, 1'b0);

    // Reset in the middle of a WAIT
    for (int i = 0; i < 3; i++) push_ev(2'd0, 12'(80 + i), 16'd20, 8'd11, 16'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midwait_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midwait_rst_fifo_count", fifo_count, 0);
    check_eq("midwait_rst_busy", busy, 0);
    check_eq("midwait_rst_track_valid", track_valid, 0);
    check_eq("midwait_rst_ev_ready", ev_ready, 1);
    check_eq("midwait_rst_note_code", note_code, 0);
    rst_n = 1'b1;
    mq.delete();
    m_note = '0; m_dur = '0; m_vel = '0;
    @(negedge clk);

`ifdef SEQ_LOOP_EN
    // Looping two events with 1 ms gaps, then drain the rotated queue
    push_ev(2'd0, 12'd40, 16'd7, 8'd1, 16'd1);
    push_ev(2'd1, 12'd41, 16'd8, 8'd2, 16'd1);
    play(30, 1'b1);
    play(-1, 1'b0);
`endif

    // Randomized rounds, some interrupted by stop and then resumed
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        push_ev(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
                16'($urandom), 8'($urandom), 16'($urandom_range(0, 3)));
      sr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
      play(sr, 1'b0);
      if (mq.size() != 0) play(-1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_event_sequencer.md
Name: note_event_sequencer

Overview:
Host-loaded event player that produces the note-command interface consumed by multi_track_synthesizer: per-track track_valid pulses with note_code, duration_ms and velocity. Events are buffered in an internal FIFO and issued with millisecond-accurate inter-event gaps derived from the system clock. It replaces bench-driven note stimulus in synthesizable top levels.

Parameters:
CLOCK_FREQ, 44100000, system clock in Hz; localparam TICK_DIV = CLOCK_FREQ/1000 cycles per ms (must be >= 1)
NUM_TRACKS, 4, number of synthesizer tracks
DEPTH, 16, event FIFO entries (power of 2)

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  synchronous active-low reset
ev_valid  in  1  host event write request
ev_ready  out  1  FIFO can accept; push = ev_valid && ev_ready
ev_track  in  $clog2(NUM_TRACKS)  target track index
ev_note  in  12  note code (MIDI number)
ev_duration  in  16  note duration, ms
ev_velocity  in  8  velocity
ev_gap_ms  in  16  wait after issuing this event before fetching the next
start  in  1  begin or resume playback (honoured in IDLE only)
stop  in  1  abort playback
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: FIFO found empty during playback
fifo_count  out  $clog2(DEPTH)+1  occupied entries
track_valid  out  NUM_TRACKS  one-hot, one-cycle command pulse
note_code  out  NUM_TRACKS*12  per-track field, track i at [12i+11:12i]
duration_ms  out  NUM_TRACKS*16  per-track field
velocity  out  NUM_TRACKS*8  per-track field

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0 except ev_ready=1; FIFO flushed; FSM -> IDLE; ms prescaler and gap counter cleared. Reset mid-playback aborts immediately.
- FIFO: ev_ready = (fifo_count < DEPTH); push while full impossible; pushes accepted in every state; simultaneous push and pop leaves fifo_count unchanged; pointers wrap modulo DEPTH.
- FSM states: IDLE, FETCH, ISSUE, WAIT.
- IDLE: start -> FETCH. start && stop in the same cycle: stop wins (stay IDLE).
- FETCH: FIFO empty -> IDLE, done=1 in the first IDLE cycle. Otherwise pop the head into the event register -> ISSUE.
- ISSUE (one cycle): if ev_track < NUM_TRACKS, set track_valid[ev_track]=1 and load that track's note/duration/velocity fields. Fields hold until the next event for the same track; other tracks' fields are untouched. An out-of-range track issues no pulse but its gap is honoured. Next state: gap==0 -> FETCH, else WAIT.
- WAIT: prescaler counts TICK_DIV cycles per ms and the gap counter decrements on each tick; at 0 -> FETCH. WAIT lasts exactly gap*TICK_DIV cycles.
- Timing: with an ISSUE at cycle t, the next ISSUE is at t+gap*TICK_DIV+2 (gap 0 gives t+2).
- stop in FETCH/ISSUE/WAIT: -> IDLE at the next edge. No further pulses; track_valid is 0 from that edge. The event being issued in that cycle still pulses. Remaining gap is discarded; FIFO contents are retained, so a later start resumes with the next queued event. done is not pulsed on stop.
- track_valid is all-zero outside ISSUE.

Optional Feature:
Macro SEQ_LOOP_EN.
- Defined: adds input loop (1 bit). In FETCH with loop=1, the popped event is simultaneously re-pushed at the tail, so fifo_count is unchanged and the sequence repeats until stop. ev_ready is forced 0 during that FETCH cycle. With loop=0, or an empty FIFO, behaviour is as base.
- Undefined: no loop port; events are consumed once.

Test Plan:
1. Reset with CLOCK_FREQ=4000 (TICK_DIV=4), DEPTH=16 -> all track_valid/note fields 0, ev_ready=1, fifo_count=0, busy=0, done=0.
2. Push track 0 events: notes 48,50,52,53,55, duration 500, velocity 127, gap 2; pulse start -> track_valid=0001 at t, t+10, t+20, t+30, t+40; note_code[11:0] is 48..55 in order; duration_ms[15:0]=500; done=1 at t+50; busy=0 afterward.
3. Push 16 events -> ev_ready=0, fifo_count=16, 17th write ignored. Start -> after the first pop fifo_count=15, ev_ready=1.
4. Events (track2, note 60, gap 0) then (track1, note 64, gap 0) -> track_valid=0100 at t, 0010 at t+2; note_code[35:24]=60 is retained; note_code[23:12]=64.
5. Three events with gap 5; assert stop 3 cycles into the first WAIT -> IDLE next cycle, no pulse, fifo_count=2. Restart -> second event issues 2 cycles after start.
6. rst_n low mid-WAIT -> fifo_count=0, IDLE. With SEQ_LOOP_EN and loop=1, two events (gap 1) -> pulses repeat every 6 cycles, alternating, until stop; fifo_count stays 2.
